// File: rtl/ring_nic.sv
// rtl/ring_nic.sv - ring router network interface with single-entry injection/ejection buffers
// Processor reaches both buffers through a 2-bit register map; injection waits for matching ring phase.
module ring_nic #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  input  logic             nicEn,
  input  logic             nicWrEn,
  output logic             net_so,
  input  logic             net_ro,
  output logic [WIDTH-1:0] net_do,
  input  logic             net_polarity,
  input  logic             net_si,
  output logic             net_ri,
  input  logic [WIDTH-1:0] net_di
);

  localparam logic [1:0] ADDR_EJ_BUF  = 2'b00;
  localparam logic [1:0] ADDR_EJ_STAT = 2'b01;
  localparam logic [1:0] ADDR_IN_BUF  = 2'b10;
  localparam logic [1:0] ADDR_IN_STAT = 2'b11;

  logic             in_full_q, in_full_d;
  logic [WIDTH-1:0] in_buf_q, in_buf_d;
  logic             out_full_q, out_full_d;
  logic [WIDTH-1:0] out_buf_q, out_buf_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;

  logic rd_en;
  logic wr_en;
  logic send;

  assign rd_en = nicEn & ~nicWrEn;
  assign wr_en = nicEn & nicWrEn;

  // The VC bit picks the ring phase; reset suppresses the strobe so a discarded packet never leaks out.
  assign send   = out_full_q & net_ro & (net_polarity == out_buf_q[WIDTH-1]) & ~reset;
  assign net_so = send;
  assign net_do = out_buf_q;
  assign net_ri = ~in_full_q;
  assign d_out  = d_out_q;

  always_comb begin
    in_full_d  = in_full_q;
    in_buf_d   = in_buf_q;
    out_full_d = out_full_q;
    out_buf_d  = out_buf_q;
    d_out_d    = d_out_q;

    // Capture and processor drain are exclusive: capture needs an empty buffer, drain a full one.
    if (net_si && !in_full_q) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end

    if (send) begin
      out_full_d = 1'b0;
    end

    if (wr_en && addr == ADDR_IN_BUF && !out_full_q) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end

    if (rd_en) begin
      case (addr)
        ADDR_EJ_BUF: begin
          d_out_d = in_buf_q;
          if (in_full_q) begin
            in_full_d = 1'b0;
          end
        end
        ADDR_EJ_STAT: d_out_d = {{(WIDTH-1){1'b0}}, in_full_q};
        ADDR_IN_BUF:  d_out_d = out_buf_q;
        ADDR_IN_STAT: d_out_d = {{(WIDTH-1){1'b0}}, out_full_q};
        default:      d_out_d = d_out_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_full_q  <= 1'b0;
      in_buf_q   <= '0;
      out_full_q <= 1'b0;
      out_buf_q  <= '0;
      d_out_q    <= '0;
    end else begin
      in_full_q  <= in_full_d;
      in_buf_q   <= in_buf_d;
      out_full_q <= out_full_d;
      out_buf_q  <= out_buf_d;
      d_out_q    <= d_out_d;
    end
  end

endmodule

// File: doc/ring_nic.md
Name: ring_nic

Overview:
- Network interface controller between a processor core and the PE port of a ring router.
- Holds one single-entry injection buffer (processor to network) and one single-entry ejection buffer (network to processor), each with a full flag.
- The processor reaches both buffers and their status through a 2-bit register address space.
- Injection is gated by the router's polarity so a packet leaves only in the phase matching its virtual-channel bit.

Parameters:
- WIDTH, 64, packet/data width. Bit WIDTH-1 is the VC bit; bit WIDTH-2 is the direction (1=ccw, 0=cw); bits [55:48] are the hop count. The NIC passes these fields unmodified.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  2  register select: 00 ejection buffer, 01 ejection status, 10 injection buffer, 11 injection status.
- d_in  in  WIDTH  processor write data.
- d_out  out  WIDTH  processor read data, registered.
- nicEn  in  1  access enable.
- nicWrEn  in  1  1=write, 0=read; meaningful only with nicEn=1.
- net_so  out  1  send strobe to router PE input (router pesi).
- net_ro  in  1  router ready to accept (router peri).
- net_do  out  WIDTH  packet to router (router pedi).
- net_polarity  in  1  ring phase from router/clock generator.
- net_si  in  1  router sends packet to NIC (router peso).
- net_ri  out  1  NIC ready to accept (router pero).
- net_di  in  WIDTH  packet from router (router pedo).

Behaviour:
- Reset (sync, active-high) drives in_full=0, out_full=0, both buffers=0, d_out=0. This gives net_so=0, net_ri=1, net_do=0. Reset mid-transfer discards buffered packets; no strobe is emitted in the reset cycle.
- Ejection path:
  - net_ri = ~in_full (combinational from the flag).
  - On net_si=1 with net_ri=1: in_buf<=net_di, in_full<=1.
  - net_si while net_ri=0 is a router protocol violation; the NIC ignores it and keeps in_buf.
- Injection path:
  - net_so = out_full & net_ro & (net_polarity == out_buf[WIDTH-1]). net_do = out_buf at all times.
  - In a cycle with net_so=1, out_full<=0 at the next edge. Exactly one strobe per packet.
  - If the polarity mismatches or net_ro=0, the packet is held indefinitely; there is no timeout.
- Processor writes (nicEn=1, nicWrEn=1):
  - addr=10 and out_full=0: out_buf<=d_in, out_full<=1.
  - addr=10 and out_full=1: write dropped. This includes the cycle in which net_so=1; software must poll status first.
  - Writes to 00/01/11 have no effect.
- Processor reads (nicEn=1, nicWrEn=0), with d_out updated at the next edge (1-cycle latency):
  - 00: d_out<=in_buf and in_full<=0. Reading while empty returns the stale buffer with no flag change.
  - 01: d_out<={0..., in_full}.
  - 10: d_out<=out_buf.
  - 11: d_out<={0..., out_full}.
- With nicEn=0, d_out holds its previous value.
- Simultaneous events:
  - Ejection read at addr 00 in the same cycle as net_si: impossible, since net_si needs net_ri=1, which needs in_full=0.
  - If a read of 00 clears in_full, net_ri rises on the following cycle, not the same one.
  - Injection send and a processor write of 10 in the same cycle: the write is dropped (out_full still 1 that cycle).
  - Ejection capture and injection send proceed independently in the same cycle.
- Throughput: at most one packet per 2 cycles per direction, limited by the polarity alternation.

Test Plan:
- Reset: assert reset 2 cycles -> net_so=0, net_ri=1, d_out=0; a status read at 01 and 11 returns 0.
- Injection, polarity gated: write 10 with d_in=64'h8001_0000_0000_00AA (VC=1), net_ro=1, polarity toggling from 0 -> net_so=0 while polarity=0, net_so=1 with net_do=...AA on the first polarity=1 cycle; status 11 reads 0 afterwards.
- Injection backpressure: buffered packet with net_ro=0 for 5 cycles -> net_so stays 0; a second write to 10 is dropped (read 10 returns the first packet); net_ro=1 with matching polarity -> single strobe.
- Ejection: net_si=1, net_di=64'h0000_0000_0000_1234 -> next cycle net_ri=0 and status 01 reads 1; read 00 -> d_out=...1234 one cycle later, then net_ri=1.
- Ejection full: second net_si while net_ri=0 with net_di=...5678 -> buffer still ...1234.
- Reset mid-operation: both buffers full, reset for 1 cycle -> both flags 0, net_so=0, net_ri=1 the cycle after.
